// File: rtl/mips_multicycle_ctrl_if.sv
// Shared memory port handshake between the multi-cycle control FSM and memory.
// The controller holds its request and address select until mem_ready.
interface mips_multicycle_ctrl_if;
    logic mem_read;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  i_or_d,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath with a shared memory port.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcode/funct locks into TRAP.
module mips_multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mips_multicycle_ctrl_if.master mem,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 alu_zero,
    output logic                 ir_write,
    output logic                 pc_en,
    output logic [1:0]           pc_source,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alu_ctrl,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic [3:0]           state,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic                 illegal_instr,
`endif
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EXEC = 4'd11,
        ADDI_WB   = 4'd12,
        TRAP      = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Where an unsupported opcode/funct goes: a lock-up state or a NOP.
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_e ILL_S = TRAP;
`else
    localparam state_e ILL_S = FETCH;
`endif

    state_e                 state_q, state_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   retire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.i_or_d    = 1'b0;
        ir_write      = 1'b0;
        pc_en         = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_ctrl      = 4'b0000;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem.mem_read = 1'b1;
                alu_src_b    = 2'b01;
                alu_ctrl     = ALU_ADD;
                ir_write     = mem.mem_ready;
                pc_en        = mem.mem_ready;
                if (mem.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                unique case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EXEC;
                    default:      state_d = ILL_S;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem.mem_read = 1'b1;
                mem.i_or_d   = 1'b1;
                if (mem.mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                mem.mem_write = 1'b1;
                mem.i_or_d    = 1'b1;
                if (mem.mem_ready) state_d = FETCH;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                state_d   = ALU_WB;
                unique case (funct)
                    6'b100000: alu_ctrl = ALU_ADD;
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   state_d  = ILL_S;
                endcase
            end
            ALU_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_source = 2'b01;
                pc_en     = alu_zero;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
                state_d   = FETCH;
            end
            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                illegal_instr = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // An instruction retires whenever the FSM re-enters FETCH from elsewhere.
    always_comb begin
        retire    = (state_d == FETCH) && (state_q != FETCH) && (state_q != IDLE);
        instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle variant of the processor, where one memory port is shared by instruction fetch and load/store. It sequences the datapath through fetch, decode, execute, memory and writeback. It drives every datapath strobe and mux select, handles variable memory latency with a ready handshake, and counts retired instructions.

Parameters:
INSTRET_W, 32, width of the retired-instruction counter; wraps modulo 2^INSTRET_W.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
opcode  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
alu_zero  in  1  ALU zero flag
mem_ready  in  1  memory completed current access this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
ir_write  out  1  load instruction register
pc_en  out  1  PC write enable
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_ctrl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=memory data
reg_write  out  1  register file write enable
state  out  4  current state, debug
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- States and codes: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=13.
- Reset: reset_n low forces state=IDLE and instret=0 immediately, mid-instruction included. IDLE drives all outputs 0. IDLE->FETCH on the first clk edge after release.
- Outputs are decoded from state only; unlisted outputs are 0. Exceptions: ir_write/pc_en in FETCH also use mem_ready, and pc_en in BRANCH uses alu_zero.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_source=00. ir_write=pc_en=mem_ready. Stays until mem_ready=1, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add. Next state: lw(100011)/sw(101011)->MEM_ADDR; R-type(000000)->EXECUTE; beq(000100)->BRANCH; j(000010)->JUMP; addi(001000)->ADDI_EXEC; other->see Optional Feature.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add. Next: lw->MEM_READ, sw->MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00. alu_ctrl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other funct->illegal. Then ALU_WB.
- ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_source=01, pc_en=alu_zero -> FETCH.
- JUMP: pc_source=10, pc_en=1 -> FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, add -> ADDI_WB. ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- Request hold: mem_read/mem_write stay asserted, and the address select stays stable, while mem_ready=0. mem_ready is ignored outside FETCH/MEM_READ/MEM_WRITE.
- instret increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JUMP or ADDI_WB, whether or not the branch is taken. Wraps to 0.
- Latency with mem_ready tied 1: R-type 4 cycles, addi 4, sw 4, lw 5, beq 3, j 3.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN. Defined: an unsupported opcode in DECODE, or an unsupported funct in EXECUTE, enters TRAP. TRAP drives all outputs 0, never exits except by reset, and does not increment instret. An extra output illegal_instr (1 bit) is 1 only in TRAP. Undefined: the same cases go straight to FETCH as a NOP that does increment instret, TRAP is unreachable, and the illegal_instr port does not exist.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> state=0, all strobes 0, instret=0. Release -> FETCH on next edge with mem_read=1 and i_or_d=0.
- R-type add: mem_ready=1, opcode=000000, funct=100000 -> states 1,2,7,8,1. alu_ctrl=0010 in EXECUTE, reg_write=1 and reg_dst=1 in ALU_WB, instret=1.
- lw with memory wait: mem_ready low for 2 cycles in FETCH and 3 in MEM_READ -> mem_read held high throughout, ir_write/pc_en pulse exactly once, 10 cycles total, reg_write with mem_to_reg=1 in MEM_WB.
- beq: alu_zero=1 -> pc_en=1 and pc_source=01 in BRANCH. alu_zero=0 -> pc_en=0. instret increments in both cases.
- Async reset mid-operation: reset_n falls during MEM_WRITE with mem_ready=0 -> mem_write drops to 0 without a clock edge, state=0, instret=0.
- Illegal opcode 111111: with CTRL_ILLEGAL_TRAP_EN -> state=13, illegal_instr=1, stuck for 20 cycles. Without -> returns to FETCH, instret+1.
